rmt_cfg_data_arbiter: RTL and testbench
=======================================

Name: rmt_cfg_data_arbiter

Overview:
- Packet-atomic 2:1 AXI-Stream arbiter in front of rmt_wrapper's slave AXIS port.
- Merges a control-plane stream (port 0: stage/parser/state configuration packets) with a data-plane stream (port 1: traffic) into a single stream.
- Port 0 has priority. A starvation guard forces one port-1 packet after MAX_CFG_BURST consecutive port-0 wins that occurred while port 1 was waiting.
- Output is registered. Per-port packet counters are provided for debug.

Parameters:
- C_S_AXIS_DATA_WIDTH, 512, tdata width on all ports.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width on all ports.
- MAX_CFG_BURST, 4, maximum consecutive port-0 grants while port 1 is pending; range 1..255.
- CNT_WIDTH, 32, width of the packet counters.

Ports:
- clk  in  1  single clock for all logic.
- areset  in  1  asynchronous, active-high reset.
- s0_axis_tdata/tkeep/tuser/tvalid/tlast  in  512/64/128/1/1  config stream; tkeep width is C_S_AXIS_DATA_WIDTH/8.
- s0_axis_tready  out  1
- s1_axis_tdata/tkeep/tuser/tvalid/tlast  in  512/64/128/1/1  data stream.
- s1_axis_tready  out  1
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  512/64/128/1/1  merged stream to rmt_wrapper.
- m_axis_tready  in  1
- pkt_cnt0  out  CNT_WIDTH  port-0 packets forwarded.
- pkt_cnt1  out  CNT_WIDTH  port-1 packets forwarded.
- grant  out  2  one-hot current grant; 00 when IDLE.

Behaviour:
- Reset (async assert, sync deassert internally):
  - state=IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep/tuser=0.
  - s0/s1_axis_tready=0, grant=00, pkt_cnt0/1=0, starve_cnt=0.
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE: both treadys are 0. The decision is made on the clock edge:
  - s0_tvalid && (!s1_tvalid || starve_cnt < MAX_CFG_BURST) -> GRANT0.
  - Port-0 grant while s1_tvalid=1: starve_cnt+1, saturating at MAX_CFG_BURST.
  - Port-0 grant while s1_tvalid=0: starve_cnt=0.
  - Else s1_tvalid -> GRANT1, starve_cnt=0.
  - Else stay in IDLE.
- GRANTx:
  - out_free = !m_axis_tvalid || m_axis_tready.
  - sx_axis_tready = out_free; the non-granted port's tready is 0.
  - A beat is accepted when sx_tvalid && sx_tready. It is loaded into the output register (tdata, tkeep, tuser, tlast) with m_axis_tvalid=1 on the next edge.
  - If out_free and no beat is accepted, m_axis_tvalid clears.
  - Output register holds unchanged while m_axis_tvalid && !m_axis_tready.
  - Accepted beat with tlast=1: pkt_cntx+1 (wraps modulo 2^CNT_WIDTH), next state IDLE.
- Latency and throughput:
  - Input accept edge N -> beat visible on m_axis at N+1.
  - Full throughput within a packet.
  - One idle cycle between packets (the IDLE decision cycle).
- A packet is never interleaved. Once granted, the other port waits until tlast is accepted, regardless of starvation or tvalid gaps.
- tvalid gaps inside a packet: stay in GRANTx, emit nothing.
- Single-beat packets (tlast on first beat) are legal: GRANTx for exactly one accepted beat.
- Mid-packet reset: all state clears immediately. The partial packet is lost and downstream sees tvalid drop.
- tkeep/tuser are passed through unmodified; no tkeep validity checking.

Test Plan:
- Port-0 only: 2-beat packet (tkeep ffff_ffff_ffff_ffff, then 0000_0000_000f_ffff) -> identical beats on m_axis, 1 cycle after acceptance; pkt_cnt0=1; grant goes 01 then 00.
- Both ports continuously valid, MAX_CFG_BURST=4, single-beat packets -> grant order 0,0,0,0,1,0,0,0,0,1,…; after 10 packets pkt_cnt0=8, pkt_cnt1=2.
- Port-1 3-beat packet in progress, port 0 raises tvalid at beat 2 -> port-1 beats 1..3 forwarded contiguously, port-0 packet follows after the IDLE cycle; no interleave.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 3-beat packet -> output data stable while stalled, no beat lost or duplicated, source tready low on stall cycles.
- areset pulsed during beat 2 of a 3-beat packet -> m_axis_tvalid=0 asynchronously, counters 0, grant=00; next packet forwarded normally.
- Counter wrap with CNT_WIDTH=4: 17 port-1 packets -> pkt_cnt1=1.

Source files
------------

// File: rtl/rmt_cfg_data_arbiter.sv
// Packet-atomic 2:1 AXI-Stream arbiter merging the config stream (port 0)
// with the data stream (port 1) into rmt_wrapper's slave port.
// Port 0 has priority. A starvation guard hands port 1 one packet after
// MAX_CFG_BURST back-to-back port-0 wins taken while port 1 was waiting.
module rmt_cfg_data_arbiter #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned MAX_CFG_BURST        = 4,
    parameter int unsigned CNT_WIDTH            = 32
) (
    input  logic                              clk,
    input  logic                              areset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
    input  logic                              s0_axis_tvalid,
    input  logic                              s0_axis_tlast,
    output logic                              s0_axis_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
    input  logic                              s1_axis_tvalid,
    input  logic                              s1_axis_tlast,
    output logic                              s1_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,

    output logic [CNT_WIDTH-1:0]              pkt_cnt0,
    output logic [CNT_WIDTH-1:0]              pkt_cnt1,
    output logic [1:0]                        grant
);

    localparam int unsigned KEEP_WIDTH   = C_S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned STARVE_WIDTH = 8;
    localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(MAX_CFG_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [STARVE_WIDTH-1:0] starve_cnt;
    logic [STARVE_WIDTH-1:0] starve_next;
    logic [1:0]              grant_next;

    logic [1:0]              rst_sync;
    logic                    rst;
    logic                    out_free;
    logic                    acc0;
    logic                    acc1;
    logic                    acc;

    // Reset bridge: asserts with areset, releases two clocks after it drops
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rst_sync <= 2'b11;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end

    assign rst = rst_sync[1];

    // Output slot can take a beat when empty or draining this cycle
    assign out_free       = !m_axis_tvalid || m_axis_tready;
    assign s0_axis_tready = (state == GRANT0) && out_free;
    assign s1_axis_tready = (state == GRANT1) && out_free;
    assign acc0           = s0_axis_tvalid && s0_axis_tready;
    assign acc1           = s1_axis_tvalid && s1_axis_tready;
    assign acc            = acc0 || acc1;

    // State, starvation counter and grant registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            grant      <= 2'b00;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            grant      <= grant_next;
        end
    end

    // Arbitration decision in IDLE; packet ends on accepted tlast
    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        case (state)
            IDLE: begin
                if (s0_axis_tvalid && (!s1_axis_tvalid || (starve_cnt < STARVE_MAX))) begin
                    state_next = GRANT0;
                    if (s1_axis_tvalid) begin
                        starve_next = (starve_cnt < STARVE_MAX) ?
                                      starve_cnt + STARVE_WIDTH'(1) : STARVE_MAX;
                    end else begin
                        starve_next = '0;
                    end
                end else if (s1_axis_tvalid) begin
                    state_next  = GRANT1;
                    starve_next = '0;
                end
            end
            GRANT0: begin
                if (acc0 && s0_axis_tlast) begin
                    state_next = IDLE;
                end
            end
            GRANT1: begin
                if (acc1 && s1_axis_tlast) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        grant_next = {state_next == GRANT1, state_next == GRANT0};
    end

    // Output register: load accepted beat, drain when free, hold when stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
        end else if (out_free) begin
            m_axis_tvalid <= acc;
            if (acc1) begin
                m_axis_tdata <= s1_axis_tdata;
                m_axis_tkeep <= KEEP_WIDTH'(s1_axis_tkeep);
                m_axis_tuser <= s1_axis_tuser;
                m_axis_tlast <= s1_axis_tlast;
            end else if (acc0) begin
                m_axis_tdata <= s0_axis_tdata;
                m_axis_tkeep <= KEEP_WIDTH'(s0_axis_tkeep);
                m_axis_tuser <= s0_axis_tuser;
                m_axis_tlast <= s0_axis_tlast;
            end
        end
    end

    // Per-port forwarded packet counters, wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (acc0 && s0_axis_tlast) begin
                pkt_cnt0 <= pkt_cnt0 + CNT_WIDTH'(1);
            end
            if (acc1 && s1_axis_tlast) begin
                pkt_cnt1 <= pkt_cnt1 + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_rmt_cfg_data_arbiter.sv
// Scoreboard bench for rmt_cfg_data_arbiter: stimulus pushes expected beats,
// a negedge monitor pops and compares every beat the arbiter emits.
`timescale 1ns/1ps
module tb_rmt_cfg_data_arbiter;

    localparam int unsigned DW = 512;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned UW = 128;
    localparam int unsigned CW = 4;
    localparam int unsigned MB = 4;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic [DW-1:0] s0_axis_tdata = '0;
    logic [KW-1:0] s0_axis_tkeep = '0;
    logic [UW-1:0] s0_axis_tuser = '0;
    logic          s0_axis_tvalid = 1'b0;
    logic          s0_axis_tlast = 1'b0;
    logic          s0_axis_tready;
    logic [DW-1:0] s1_axis_tdata = '0;
    logic [KW-1:0] s1_axis_tkeep = '0;
    logic [UW-1:0] s1_axis_tuser = '0;
    logic          s1_axis_tvalid = 1'b0;
    logic          s1_axis_tlast = 1'b0;
    logic          s1_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic [CW-1:0] pkt_cnt0;
    logic [CW-1:0] pkt_cnt1;
    logic [1:0]    grant;

    rmt_cfg_data_arbiter #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .MAX_CFG_BURST       (MB),
        .CNT_WIDTH           (CW)
    ) dut (
        .clk           (clk),
        .areset        (areset),
        .s0_axis_tdata (s0_axis_tdata),
        .s0_axis_tkeep (s0_axis_tkeep),
        .s0_axis_tuser (s0_axis_tuser),
        .s0_axis_tvalid(s0_axis_tvalid),
        .s0_axis_tlast (s0_axis_tlast),
        .s0_axis_tready(s0_axis_tready),
        .s1_axis_tdata (s1_axis_tdata),
        .s1_axis_tkeep (s1_axis_tkeep),
        .s1_axis_tuser (s1_axis_tuser),
        .s1_axis_tvalid(s1_axis_tvalid),
        .s1_axis_tlast (s1_axis_tlast),
        .s1_axis_tready(s1_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .pkt_cnt0      (pkt_cnt0),
        .pkt_cnt1      (pkt_cnt1),
        .grant         (grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
        int            gap;
    } beat_t;

    beat_t      tx0[$];
    beat_t      tx1[$];
    beat_t      exp_q[$];
    logic       rdy_q[$];
    logic [1:0] grant_log[$];
    logic [1:0] prev_grant = 2'b00;

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;

    logic          hs0 = 1'b0;
    logic          hs1 = 1'b0;
    logic          stall_prev = 1'b0;
    logic          lat_pend = 1'b0;
    logic [DW-1:0] lat_data = '0;
    logic [DW-1:0] st_data = '0;
    logic [KW-1:0] st_keep = '0;
    logic [UW-1:0] st_user = '0;
    logic          st_last = 1'b0;

    function automatic beat_t mk_beat(int port, int pkt, int beat, bit last, int gap);
        beat_t         b;
        logic [DW-1:0] d;
        d               = '0;
        d[31:0]         = {8'(port), 16'(pkt), 8'(beat)};
        d[DW-1 -: 32]   = 32'hC0DE_0000 | 32'(pkt);
        b.data          = d;
        b.keep          = last ? 64'h0000_0000_000f_ffff : 64'hffff_ffff_ffff_ffff;
        b.user          = UW'({8'(port), 8'(beat), 16'(pkt)});
        b.last          = last;
        b.gap           = gap;
        return b;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Queue a packet at a source; gap_last adds idle cycles before the final beat
    task automatic send_pkt(int port, int pkt, int nbeats, int gap_first, int gap_last);
        for (int i = 0; i < nbeats; i++) begin
            beat_t b;
            int    g;
            g = (i == 0) ? gap_first : ((i == nbeats - 1) ? gap_last : 0);
            b = mk_beat(port, pkt, i, (i == nbeats - 1), g);
            if (port == 0) tx0.push_back(b);
            else           tx1.push_back(b);
        end
    endtask

    task automatic expect_pkt(int port, int pkt, int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            exp_q.push_back(mk_beat(port, pkt, i, (i == nbeats - 1), 0));
        end
    endtask

    // Source drivers, sink ready pattern and output monitor
    always @(negedge clk) begin
        beat_t b;
        beat_t e;
        if (hs0 && tx0.size() > 0) void'(tx0.pop_front());
        if (hs1 && tx1.size() > 0) void'(tx1.pop_front());
        s0_axis_tvalid = 1'b0;
        if (tx0.size() > 0) begin
            b = tx0[0];
            if (b.gap > 0) begin
                b.gap  = b.gap - 1;
                tx0[0] = b;
            end else begin
                s0_axis_tdata  = b.data;
                s0_axis_tkeep  = b.keep;
                s0_axis_tuser  = b.user;
                s0_axis_tlast  = b.last;
                s0_axis_tvalid = 1'b1;
            end
        end
        s1_axis_tvalid = 1'b0;
        if (tx1.size() > 0) begin
            b = tx1[0];
            if (b.gap > 0) begin
                b.gap  = b.gap - 1;
                tx1[0] = b;
            end else begin
                s1_axis_tdata  = b.data;
                s1_axis_tkeep  = b.keep;
                s1_axis_tuser  = b.user;
                s1_axis_tlast  = b.last;
                s1_axis_tvalid = 1'b1;
            end
        end
        m_axis_tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
        #1;
        if (areset) begin
            hs0        = 1'b0;
            hs1        = 1'b0;
            stall_prev = 1'b0;
            lat_pend   = 1'b0;
        end else begin
            if (lat_pend) begin
                check("latency", {63'd0, m_axis_tvalid && (m_axis_tdata === lat_data)}, 64'd1);
            end
            if (stall_prev) begin
                checks++;
                if (!m_axis_tvalid || m_axis_tdata !== st_data || m_axis_tkeep !== st_keep ||
                    m_axis_tuser !== st_user || m_axis_tlast !== st_last) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b data=%0h expected held data=%0h",
                             m_axis_tvalid, m_axis_tdata[63:0], st_data[63:0]);
                end
            end
            if (m_axis_tvalid && !m_axis_tready) begin
                stall_cnt++;
                check("stall_src_ready", {62'd0, s0_axis_tready, s1_axis_tready}, 64'd0);
                st_data    = m_axis_tdata;
                st_keep    = m_axis_tkeep;
                st_user    = m_axis_tuser;
                st_last    = m_axis_tlast;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data=%0h expected none", m_axis_tdata[63:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (m_axis_tdata !== e.data || m_axis_tkeep !== e.keep ||
                        m_axis_tuser !== e.user || m_axis_tlast !== e.last) begin
                        errors++;
                        $display("FAIL beat: got data=%0h keep=%0h last=%0b expected data=%0h keep=%0h last=%0b",
                                 m_axis_tdata[63:0], m_axis_tkeep, m_axis_tlast,
                                 e.data[63:0], e.keep, e.last);
                    end
                end
            end
            if (grant != prev_grant) begin
                if (grant != 2'b00) grant_log.push_back(grant);
                prev_grant = grant;
            end
            hs0      = s0_axis_tvalid && s0_axis_tready;
            hs1      = s1_axis_tvalid && s1_axis_tready;
            lat_pend = hs0 || hs1;
            lat_data = hs0 ? s0_axis_tdata : s1_axis_tdata;
        end
    end

    task automatic reset_checks(string name);
        check({name, "_tvalid"}, {63'd0, m_axis_tvalid}, 64'd0);
        check({name, "_cnt0"},   64'(pkt_cnt0), 64'd0);
        check({name, "_cnt1"},   64'(pkt_cnt1), 64'd0);
        check({name, "_grant"},  64'(grant), 64'd0);
        check({name, "_srdy"},   {62'd0, s0_axis_tready, s1_axis_tready}, 64'd0);
    endtask

    task automatic flush_tb();
        tx0.delete();
        tx1.delete();
        exp_q.delete();
        rdy_q.delete();
        grant_log.delete();
        hs0       = 1'b0;
        hs1       = 1'b0;
        stall_cnt = 0;
    endtask

    task automatic do_reset(string name);
        areset = 1'b1;
        repeat (2) @(negedge clk);
        flush_tb();
        #2;
        reset_checks(name);
        areset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic drain(string name);
        int n;
        n = 0;
        while ((tx0.size() > 0 || tx1.size() > 0 || exp_q.size() > 0 || m_axis_tvalid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats outstanding expected 0", name, exp_q.size());
        end
    endtask

    initial begin
        logic [1:0] g2 [10];
        int         n;
        g2 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

        // Port 0 alone, two-beat packet
        do_reset("t1_rst");
        send_pkt(0, 1, 2, 0, 0);
        expect_pkt(0, 1, 2);
        drain("t1");
        check("t1_cnt0", 64'(pkt_cnt0), 64'd1);
        check("t1_cnt1", 64'(pkt_cnt1), 64'd0);
        check("t1_grant_idle", 64'(grant), 64'd0);
        check("t1_glen", 64'(grant_log.size()), 64'd1);
        if (grant_log.size() > 0) check("t1_g0", 64'(grant_log[0]), 64'd1);

        // Both ports saturated, single-beat packets: starvation guard every fifth
        do_reset("t2_rst");
        for (int i = 0; i < 8; i++) send_pkt(0, i, 1, 0, 0);
        for (int i = 0; i < 2; i++) send_pkt(1, i, 1, 0, 0);
        for (int i = 0; i < 4; i++) expect_pkt(0, i, 1);
        expect_pkt(1, 0, 1);
        for (int i = 4; i < 8; i++) expect_pkt(0, i, 1);
        expect_pkt(1, 1, 1);
        drain("t2");
        check("t2_cnt0", 64'(pkt_cnt0), 64'd8);
        check("t2_cnt1", 64'(pkt_cnt1), 64'd2);
        check("t2_glen", 64'(grant_log.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < grant_log.size()) check($sformatf("t2_g%0d", i), 64'(grant_log[i]), 64'(g2[i]));
        end

        // Port 1 packet in flight with a tvalid gap; port 0 arrives mid-packet
        do_reset("t3_rst");
        send_pkt(1, 3, 3, 0, 1);
        send_pkt(0, 3, 2, 2, 0);
        expect_pkt(1, 3, 3);
        expect_pkt(0, 3, 2);
        drain("t3");
        check("t3_cnt0", 64'(pkt_cnt0), 64'd1);
        check("t3_cnt1", 64'(pkt_cnt1), 64'd1);
        check("t3_glen", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) begin
            check("t3_g0", 64'(grant_log[0]), 64'd2);
            check("t3_g1", 64'(grant_log[1]), 64'd1);
        end

        // Downstream backpressure during a three-beat packet
        do_reset("t4_rst");
        rdy_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        send_pkt(0, 4, 3, 0, 0);
        expect_pkt(0, 4, 3);
        drain("t4");
        check("t4_stalls_seen", {63'd0, stall_cnt > 0}, 64'd1);
        check("t4_cnt0", 64'(pkt_cnt0), 64'd1);

        // Reset pulsed while beat 2 sits in the output register
        do_reset("t5_rst");
        send_pkt(1, 5, 3, 0, 0);
        expect_pkt(1, 5, 3);
        n = 0;
        while (!m_axis_tvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_first_beat_seen", {63'd0, m_axis_tvalid}, 64'd1);
        @(posedge clk);
        #2;
        areset = 1'b1;
        #1;
        reset_checks("t5_async");
        repeat (2) @(negedge clk);
        flush_tb();
        areset = 1'b0;
        repeat (4) @(negedge clk);
        send_pkt(0, 6, 2, 0, 0);
        expect_pkt(0, 6, 2);
        drain("t5");
        check("t5_cnt0", 64'(pkt_cnt0), 64'd1);
        check("t5_cnt1", 64'(pkt_cnt1), 64'd0);

        // Counter wrap at four bits: 17 packets leave a count of 1
        do_reset("t6_rst");
        for (int i = 0; i < 17; i++) begin
            send_pkt(1, i, 1, 0, 0);
            expect_pkt(1, i, 1);
        end
        drain("t6");
        check("t6_cnt1", 64'(pkt_cnt1), 64'd1);
        check("t6_cnt0", 64'(pkt_cnt0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1);
    end

endmodule
